// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
//   Multi-port integer register file sitting between decode (reads) and
//   writeback (writes) of the pipelined core.
//   - NUM_RD combinational read ports, NUM_WR write ports (higher index wins).
//   - Same-cycle write-to-read bypass; register 0 is hardwired to zero.
//   - After reset a CLEAR sequence zeroes one register per cycle (DEPTH
//     cycles); init_busy is high while it runs.
//   - Optional pending scoreboard, enabled by defining REG_FILE_SCOREBOARD_EN.
//
// Ports
//   clk        in   1                  clock, all state on posedge
//   rst        in   1                  synchronous active-high reset
//   rd_addr    in   NUM_RD*ADDR_W      packed read indices
//   rd_data    out  NUM_RD*DATA_WIDTH  packed read data, combinational
//   wr_en      in   NUM_WR             per-port write enable
//   wr_addr    in   NUM_WR*ADDR_W      packed write indices
//   wr_data    in   NUM_WR*DATA_WIDTH  packed write data
//   init_busy  out  1                  high while CLEAR runs (FSM state view)
//   alloc_en   in   1                  [scoreboard] mark alloc_addr pending
//   alloc_addr in   ADDR_W             [scoreboard] destination being issued
//   rd_pend    out  NUM_RD             [scoreboard] pending bit per read port
//
// Handshake: there is no valid/ready flow control; a write is taken on every
// posedge where wr_en[j] is high in READY, reads are pure combinational.
// ---------------------------------------------------------------------------
module reg_file_mp #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  output logic                         init_busy
`ifdef REG_FILE_SCOREBOARD_EN
  ,
  input  logic                         alloc_en,
  input  logic [ADDR_W-1:0]            alloc_addr,
  output logic [NUM_RD-1:0]            rd_pend
`endif
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     r_clr_cnt;
  logic [DATA_WIDTH-1:0] r_regs [DEPTH];

  logic [ADDR_W-1:0]     w_rd_addr [NUM_RD];
  logic [ADDR_W-1:0]     w_wr_addr [NUM_WR];
  logic [DATA_WIDTH-1:0] w_wr_data [NUM_WR];
  logic [DATA_WIDTH-1:0] w_rd_data [NUM_RD];
  logic [NUM_RD-1:0]     w_rd_hit;

  // Unpack the flat buses into per-port views.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    assign w_rd_addr[gi] = rd_addr[gi*ADDR_W +: ADDR_W];
    assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = w_rd_data[gi];
  end

  for (genvar gj = 0; gj < NUM_WR; gj++) begin : g_wr
    assign w_wr_addr[gj] = wr_addr[gj*ADDR_W +: ADDR_W];
    assign w_wr_data[gj] = wr_data[gj*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---------------------------------------------------------------------
  // CLEAR/READY FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == ST_CLEAR) && (r_clr_cnt == ADDR_W'(DEPTH - 1))) begin
      w_state_nxt = ST_READY;
    end
  end

  assign init_busy = (r_state == ST_CLEAR);

  // ---------------------------------------------------------------------
  // Register storage. CLEAR zeroes one entry per cycle; in READY the write
  // ports are applied in index order so the highest port wins a collision.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_regs[r_clr_cnt] <= '0;
    end else if (!rst) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (w_wr_addr[j] != '0)) begin
          r_regs[w_wr_addr[j]] <= w_wr_data[j];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read ports: x0 -> 0, else bypass from the highest matching write port,
  // else stored value. Everything reads 0 while CLEAR is running.
  // ---------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_data[i] = '0;
      w_rd_hit[i]  = 1'b0;
      if ((r_state == ST_READY) && (w_rd_addr[i] != '0)) begin
        w_rd_data[i] = r_regs[w_rd_addr[i]];
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (w_wr_addr[j] == w_rd_addr[i])) begin
            w_rd_data[i] = w_wr_data[j];
            w_rd_hit[i]  = 1'b1;
          end
        end
      end
    end
  end

`ifdef REG_FILE_SCOREBOARD_EN
  // ---------------------------------------------------------------------
  // Pending scoreboard. Clears from writeback are applied first so that an
  // allocation of the same index in the same cycle (a new producer) wins.
  // ---------------------------------------------------------------------
  logic [DEPTH-1:0] r_pend;

  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_CLEAR)) begin
      r_pend <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j]) begin
          r_pend[w_wr_addr[j]] <= 1'b0;
        end
      end
      if (alloc_en && (alloc_addr != '0)) begin
        r_pend[alloc_addr] <= 1'b1;
      end
    end
  end

  // A write landing this cycle is bypassed to the reader, so no hazard.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_pend[i] = (r_state == ST_READY) && r_pend[w_rd_addr[i]] && !w_rd_hit[i];
    end
  end
`else
  logic w_unused_hit;
  assign w_unused_hit = ^w_rd_hit;
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  localparam int DW = 64;
  localparam int D  = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             init_busy;
`ifdef REG_FILE_SCOREBOARD_EN
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic [NR-1:0]    rd_pend;
`endif

  reg_file_mp dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .init_busy (init_busy)
`ifdef REG_FILE_SCOREBOARD_EN
    ,
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .rd_pend   (rd_pend)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdl [D];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [DW-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [DW-1:0] obs, input string tag);
    logic [DW-1:0] exp;
    exp = exp_q.pop_front();
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  task automatic set_wr(input int j, input logic en, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    wr_en[j]            = en;
    wr_addr[j*AW +: AW] = a;
    wr_data[j*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] rd(input int i);
    return rd_data[i*DW +: DW];
  endfunction

  // Reference read: x0 -> 0, bypass from highest enabled write, else model.
  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (a == '0) return '0;
    v = mdl[a];
    for (int j = 0; j < NW; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*DW +: DW];
    return v;
  endfunction

  task automatic commit_model();
    for (int j = 0; j < NW; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
        mdl[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
  endtask

  task automatic wait_ready(input string tag);
    int cnt;
    cnt = 0;
    while (init_busy && cnt < 100) begin
      cnt++;
      tick();
    end
    wr_en = '0;
    push_exp(DW'(32));
    check(DW'(cnt), tag);
  endtask

  task automatic check_all_regs(input string tag);
    for (int a = 0; a < D; a++) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(D - 1 - a));
      #1;
      push_exp(mdl[a]);
      check(rd(0), tag);
      push_exp(mdl[D - 1 - a]);
      check(rd(1), tag);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [AW-1:0] ra0, ra1;
    rst = 1'b1;
    rd_addr = '0;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
`ifdef REG_FILE_SCOREBOARD_EN
    alloc_en = 1'b0;
    alloc_addr = '0;
`endif
    for (int a = 0; a < D; a++) mdl[a] = '0;

    // 1: reset, clear sequence, everything zero
    tick();
    tick();
    push_exp(DW'(1));
    check(DW'(init_busy), "busy_in_reset");
    rst = 1'b0;
    wait_ready("clear_len");
    push_exp('0);
    check(DW'(init_busy), "busy_low");
    check_all_regs("after_clear");

    // 2: bypass then stored read
    set_wr(0, 1'b1, 5'd5, 64'hDEAD);
    set_rd(0, 5'd5);
    #1;
    push_exp(64'hDEAD);
    check(rd(0), "bypass_x5");
    commit_model();
    tick();
    wr_en = '0;
    #1;
    push_exp(64'hDEAD);
    check(rd(0), "stored_x5");

    // 3: same-index collision, port 1 wins
    set_wr(0, 1'b1, 5'd7, 64'h11);
    set_wr(1, 1'b1, 5'd7, 64'h22);
    set_rd(1, 5'd7);
    #1;
    push_exp(64'h22);
    check(rd(1), "collide_bypass");
    commit_model();
    tick();
    wr_en = '0;
    #1;
    push_exp(64'h22);
    check(rd(1), "collide_stored");

    // 4: x0 stays zero
    set_wr(0, 1'b1, 5'd0, 64'hFFFF);
    set_wr(1, 1'b1, 5'd0, 64'hFFFF);
    set_rd(0, 5'd0);
    set_rd(1, 5'd0);
    #1;
    push_exp('0);
    check(rd(0), "x0_same0");
    push_exp('0);
    check(rd(1), "x0_same1");
    tick();
    wr_en = '0;
    #1;
    push_exp('0);
    check(rd(0), "x0_next");

    // random traffic against the model
    for (int c = 0; c < 40; c++) begin
      for (int j = 0; j < NW; j++)
        set_wr(j, 1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)),
               {$urandom(), $urandom()});
      ra0 = AW'($urandom_range(0, D - 1));
      ra1 = (c % 4 == 0) ? wr_addr[AW-1:0] : AW'($urandom_range(0, D - 1));
      set_rd(0, ra0);
      set_rd(1, ra1);
      #1;
      push_exp(ref_rd(ra0));
      check(rd(0), "rand_rd0");
      push_exp(ref_rd(ra1));
      check(rd(1), "rand_rd1");
      commit_model();
      tick();
    end
    wr_en = '0;
    check_all_regs("rand_final");

    // 5: reset mid-CLEAR after preload, writes ignored during CLEAR
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    push_exp(DW'(1));
    check(DW'(init_busy), "busy_mid_clear");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_wr(0, 1'b1, 5'd9, 64'h55);
    set_wr(1, 1'b1, 5'd9, 64'h66);
    set_rd(0, 5'd9);
    set_rd(1, 5'd5);
    #1;
    push_exp('0);
    check(rd(0), "clear_rd_bypass");
    push_exp('0);
    check(rd(1), "clear_rd_stored");
    wait_ready("reclear_len");
    for (int a = 0; a < D; a++) mdl[a] = '0;
    check_all_regs("after_reclear");

`ifdef REG_FILE_SCOREBOARD_EN
    // 6: pending scoreboard
    set_rd(0, 5'd3);
    set_rd(1, 5'd4);
    alloc_en = 1'b1;
    alloc_addr = 5'd3;
    #1;
    push_exp('0);
    check(DW'(rd_pend[0]), "pend_before");
    tick();
    alloc_en = 1'b0;
    #1;
    push_exp(DW'(1));
    check(DW'(rd_pend[0]), "pend_set");
    push_exp('0);
    check(DW'(rd_pend[1]), "pend_other");
    alloc_en = 1'b1;
    set_wr(0, 1'b1, 5'd3, 64'h33);
    tick();
    alloc_en = 1'b0;
    wr_en = '0;
    #1;
    push_exp(DW'(1));
    check(DW'(rd_pend[0]), "pend_set_wins");
    set_wr(1, 1'b1, 5'd3, 64'h44);
    #1;
    push_exp('0);
    check(DW'(rd_pend[0]), "pend_wr_same");
    tick();
    wr_en = '0;
    #1;
    push_exp('0);
    check(DW'(rd_pend[0]), "pend_cleared");
    alloc_en = 1'b1;
    alloc_addr = 5'd0;
    set_rd(0, 5'd0);
    tick();
    alloc_en = 1'b0;
    #1;
    push_exp('0);
    check(DW'(rd_pend[0]), "pend_x0");
`endif

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
